// File: rtl/rat_checkpoint.sv
// Speculative register alias table with per-branch snapshot slots.
// Copy saves the live map into a slot, Paste restores the live map from a slot,
// and writeback clears busy bits in the live map and in every snapshot.
module rat_checkpoint #(
  parameter int unsigned NUM_CKPT = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exception_sig,
  input  logic             mret_sig,
  input  logic             rn_en,
  input  logic [4:0]       rn_rd,
  input  logic [TAG_W-1:0] rn_tag,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [TAG_W-1:0] rs1_tag,
  output logic             rs1_busy,
  output logic [TAG_W-1:0] rs2_tag,
  output logic             rs2_busy,
  input  logic             wb_en,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic             Copy_RAT,
  input  logic [IDX_W-1:0] tail_num,
  input  logic             Paste_RAT,
  input  logic [IDX_W-1:0] head_num,
  output logic             paste_done,
  output logic             ckpt_ovw
);

  localparam int unsigned NUM_AREG = 32;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             busy;
  } map_ent_t;

  map_ent_t                live_q [NUM_AREG];
  map_ent_t                live_d [NUM_AREG];
  map_ent_t                ckpt_q [NUM_CKPT][NUM_AREG];
  map_ent_t                ckpt_d [NUM_CKPT][NUM_AREG];
  logic [NUM_CKPT-1:0]     ckpt_valid_q;
  logic [NUM_CKPT-1:0]     ckpt_valid_d;
  logic                    paste_done_q;
  logic                    paste_done_d;
  logic                    ckpt_ovw_q;
  logic                    ckpt_ovw_d;

  logic                    flush;
  logic [IDX_W-1:0]        tail_slot;
  logic [IDX_W-1:0]        head_slot;

  // Any flush source behaves exactly like reset
  assign flush = rst | exception_sig | mret_sig;

  // Slot indices wrap modulo the number of snapshot slots
  assign tail_slot = IDX_W'(32'(tail_num) % NUM_CKPT);
  assign head_slot = IDX_W'(32'(head_num) % NUM_CKPT);

  // Lookup straight from the live map; x0 is hard-wired to "ready, tag 0"
  always_comb begin
    rs1_tag  = '0;
    rs1_busy = 1'b0;
    rs2_tag  = '0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0) begin
      rs1_tag  = live_q[rs1_addr].tag;
      rs1_busy = live_q[rs1_addr].busy;
    end
    if (rs2_addr != 5'd0) begin
      rs2_tag  = live_q[rs2_addr].tag;
      rs2_busy = live_q[rs2_addr].busy;
    end
  end

  // Next-state: writeback clear first, then paste (wins) or rename + copy
  always_comb begin
    ckpt_valid_d = ckpt_valid_q;
    paste_done_d = 1'b0;
    ckpt_ovw_d   = 1'b0;

    for (int unsigned r = 0; r < NUM_AREG; r++) begin
      live_d[r] = live_q[r];
      if (wb_en && live_q[r].busy && (live_q[r].tag == wb_tag)) begin
        live_d[r].busy = 1'b0;
      end
    end

    for (int unsigned s = 0; s < NUM_CKPT; s++) begin
      for (int unsigned r = 0; r < NUM_AREG; r++) begin
        ckpt_d[s][r] = ckpt_q[s][r];
        if (wb_en && ckpt_q[s][r].busy && (ckpt_q[s][r].tag == wb_tag)) begin
          ckpt_d[s][r].busy = 1'b0;
        end
      end
    end

    if (Paste_RAT) begin
      // Redirect: same-cycle rename is wrong-path and same-cycle copy is dropped
      paste_done_d = 1'b1;
      if (ckpt_valid_q[head_slot]) begin
        for (int unsigned r = 0; r < NUM_AREG; r++) begin
          live_d[r] = ckpt_d[head_slot][r];
        end
        ckpt_valid_d = '0;
      end
    end else begin
      if (rn_en && (rn_rd != 5'd0)) begin
        live_d[rn_rd].tag  = rn_tag;
        live_d[rn_rd].busy = 1'b1;
      end
      // Snapshot includes this cycle's rename so a jump's own rd is captured
      if (Copy_RAT) begin
        for (int unsigned r = 0; r < NUM_AREG; r++) begin
          ckpt_d[tail_slot][r] = live_d[r];
        end
        ckpt_valid_d[tail_slot] = 1'b1;
        ckpt_ovw_d              = ckpt_valid_q[tail_slot];
      end
    end
  end

  // State register with synchronous reset/flush
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int unsigned r = 0; r < NUM_AREG; r++) begin
        live_q[r] <= '0;
      end
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        for (int unsigned r = 0; r < NUM_AREG; r++) begin
          ckpt_q[s][r] <= '0;
        end
      end
      ckpt_valid_q <= '0;
      paste_done_q <= 1'b0;
      ckpt_ovw_q   <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_AREG; r++) begin
        live_q[r] <= live_d[r];
      end
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        for (int unsigned r = 0; r < NUM_AREG; r++) begin
          ckpt_q[s][r] <= ckpt_d[s][r];
        end
      end
      ckpt_valid_q <= ckpt_valid_d;
      paste_done_q <= paste_done_d;
      ckpt_ovw_q   <= ckpt_ovw_d;
    end
  end

  assign paste_done = paste_done_q;
  assign ckpt_ovw   = ckpt_ovw_q;

endmodule

// File: tb/tb_rat_checkpoint.sv
// Self-checking bench for rat_checkpoint: vector table driven through a scoreboard.
module tb_rat_checkpoint;

  localparam int unsigned NUM_CKPT = 32;
  localparam int unsigned IDX_W    = 5;
  localparam int unsigned TAG_W    = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             exception_sig;
  logic             mret_sig;
  logic             rn_en;
  logic [4:0]       rn_rd;
  logic [TAG_W-1:0] rn_tag;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [TAG_W-1:0] rs1_tag;
  logic             rs1_busy;
  logic [TAG_W-1:0] rs2_tag;
  logic             rs2_busy;
  logic             wb_en;
  logic [TAG_W-1:0] wb_tag;
  logic             Copy_RAT;
  logic [IDX_W-1:0] tail_num;
  logic             Paste_RAT;
  logic [IDX_W-1:0] head_num;
  logic             paste_done;
  logic             ckpt_ovw;

  rat_checkpoint #(.NUM_CKPT(NUM_CKPT), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .exception_sig(exception_sig), .mret_sig(mret_sig),
    .rn_en(rn_en), .rn_rd(rn_rd), .rn_tag(rn_tag),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_tag(rs1_tag), .rs1_busy(rs1_busy), .rs2_tag(rs2_tag), .rs2_busy(rs2_busy),
    .wb_en(wb_en), .wb_tag(wb_tag),
    .Copy_RAT(Copy_RAT), .tail_num(tail_num), .Paste_RAT(Paste_RAT), .head_num(head_num),
    .paste_done(paste_done), .ckpt_ovw(ckpt_ovw)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] t1;
    logic       b1;
    logic [4:0] t2;
    logic       b2;
    logic       pd;
    logic       ov;
  } exp_t;

  // Negative field value means "not asserted"; fl: 0 none, 1 exception, 2 mret
  typedef struct {
    int   rd;
    int   tg;
    int   wb;
    int   cp;
    int   ps;
    int   fl;
    int   rs1;
    int   rs2;
    exp_t e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(int rd, int tg, int wb, int cp, int ps, int fl, int rs1, int rs2,
                              int t1, int b1, int t2, int b2, int pd, int ov);
    vec_t v;
    v.rd = rd; v.tg = tg; v.wb = wb; v.cp = cp; v.ps = ps; v.fl = fl;
    v.rs1 = rs1; v.rs2 = rs2;
    v.e.t1 = 5'(t1); v.e.b1 = 1'(b1); v.e.t2 = 5'(t2); v.e.b2 = 1'(b2);
    v.e.pd = 1'(pd); v.e.ov = 1'(ov);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s step %0d: got %0d expected %0d", nm, idx, act, expv);
    end
  endtask

  task automatic drive(input vec_t v);
    rn_en         = (v.rd >= 0);
    rn_rd         = (v.rd >= 0) ? 5'(v.rd) : 5'd0;
    rn_tag        = 5'(v.tg);
    wb_en         = (v.wb >= 0);
    wb_tag        = (v.wb >= 0) ? 5'(v.wb) : 5'd0;
    Copy_RAT      = (v.cp >= 0);
    tail_num      = (v.cp >= 0) ? 5'(v.cp) : 5'd0;
    Paste_RAT     = (v.ps >= 0);
    head_num      = (v.ps >= 0) ? 5'(v.ps) : 5'd0;
    exception_sig = (v.fl == 1);
    mret_sig      = (v.fl == 2);
    rs1_addr      = 5'(v.rs1);
    rs2_addr      = 5'(v.rs2);
  endtask

  task automatic check_out(input int idx);
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", idx, 0, 1);
    end else begin
      e = sb.pop_front();
      chk("rs1_tag",    idx, int'(rs1_tag),    int'(e.t1));
      chk("rs1_busy",   idx, int'(rs1_busy),   int'(e.b1));
      chk("rs2_tag",    idx, int'(rs2_tag),    int'(e.t2));
      chk("rs2_busy",   idx, int'(rs2_busy),   int'(e.b2));
      chk("paste_done", idx, int'(paste_done), int'(e.pd));
      chk("ckpt_ovw",   idx, int'(ckpt_ovw),   int'(e.ov));
    end
  endtask

  initial begin
    //                rd  tg  wb  cp  ps fl rs1 rs2  t1 b1 t2 b2 pd ov
    tbl.push_back(mk(-1,  0, -1, -1, -1, 0, 5,  0,   0, 0, 0, 0, 0, 0)); // 0 reset state
    tbl.push_back(mk( 5,  7, -1, -1, -1, 0, 5,  0,   7, 1, 0, 0, 0, 0)); // 1 rename x5->7
    tbl.push_back(mk(-1,  0,  7, -1, -1, 0, 5,  0,   7, 0, 0, 0, 0, 0)); // 2 wb 7
    tbl.push_back(mk( 3,  2, -1, -1, -1, 0, 3,  5,   2, 1, 7, 0, 0, 0)); // 3 rename x3->2
    tbl.push_back(mk(-1,  0, -1,  4, -1, 0, 3,  5,   2, 1, 7, 0, 0, 0)); // 4 copy slot 4
    tbl.push_back(mk( 3,  9, -1, -1, -1, 0, 3,  5,   9, 1, 7, 0, 0, 0)); // 5 rename x3->9
    tbl.push_back(mk(-1,  0, -1, -1,  4, 0, 3,  5,   2, 1, 7, 0, 1, 0)); // 6 paste slot 4
    tbl.push_back(mk(-1,  0, -1, -1, -1, 0, 3,  5,   2, 1, 7, 0, 0, 0)); // 7 paste_done one cycle
    tbl.push_back(mk( 6, 12, -1, -1, -1, 0, 6,  3,  12, 1, 2, 1, 0, 0)); // 8 rename x6->12
    tbl.push_back(mk(-1,  0, -1,  1, -1, 0, 6,  3,  12, 1, 2, 1, 0, 0)); // 9 copy slot 1
    tbl.push_back(mk(-1,  0, 12, -1, -1, 0, 6,  3,  12, 0, 2, 1, 0, 0)); // 10 wb 12
    tbl.push_back(mk( 6, 13, -1, -1, -1, 0, 6,  3,  13, 1, 2, 1, 0, 0)); // 11 rename x6->13
    tbl.push_back(mk(-1,  0, -1, -1,  1, 0, 6,  3,  12, 0, 2, 1, 1, 0)); // 12 paste slot 1
    tbl.push_back(mk(-1,  0, -1,  2, -1, 0, 8,  6,   0, 0,12, 0, 0, 0)); // 13 copy slot 2
    tbl.push_back(mk( 8, 15, -1, -1,  2, 0, 8,  6,   0, 0,12, 0, 1, 0)); // 14 paste + rename dropped
    tbl.push_back(mk(-1,  0, -1,  1, -1, 0, 8,  6,   0, 0,12, 0, 0, 0)); // 15 copy slot 1
    tbl.push_back(mk(-1,  0, -1,  1, -1, 0, 8,  6,   0, 0,12, 0, 0, 1)); // 16 copy slot 1 again
    tbl.push_back(mk(-1,  0, -1, -1, -1, 0, 8,  6,   0, 0,12, 0, 0, 0)); // 17 ovw one cycle
    tbl.push_back(mk( 7, 20, -1,  3, -1, 0, 7,  8,  20, 1, 0, 0, 0, 0)); // 18 rename + copy
    tbl.push_back(mk( 7, 21, -1, -1, -1, 0, 7,  8,  21, 1, 0, 0, 0, 0)); // 19 rename x7->21
    tbl.push_back(mk(-1,  0, -1, -1,  3, 0, 7,  8,  20, 1, 0, 0, 1, 0)); // 20 paste keeps jump rd
    tbl.push_back(mk( 9, 22, -1, -1, -1, 0, 9,  7,  22, 1,20, 1, 0, 0)); // 21 rename x9->22
    tbl.push_back(mk(-1,  0, -1,  5, -1, 0, 9,  7,  22, 1,20, 1, 0, 0)); // 22 copy slot 5
    tbl.push_back(mk(-1,  0, 22, -1,  5, 0, 9,  7,  22, 0,20, 1, 1, 0)); // 23 paste + wb same cycle
    tbl.push_back(mk(-1,  0, -1,  6, -1, 0, 9,  7,  22, 0,20, 1, 0, 0)); // 24 copy slot 6
    tbl.push_back(mk(-1,  0, -1,  0,  6, 0, 9,  7,  22, 0,20, 1, 1, 0)); // 25 copy + paste: paste wins
    tbl.push_back(mk(-1,  0, -1,  0, -1, 0, 9,  7,  22, 0,20, 1, 0, 0)); // 26 slot 0 never written
    tbl.push_back(mk( 4,  3, -1, -1, -1, 0, 4,  9,   3, 1,22, 0, 0, 0)); // 27 rename x4->3
    tbl.push_back(mk( 4, 11, -1,  7, -1, 1, 4,  9,   0, 0, 0, 0, 0, 0)); // 28 exception flush
    tbl.push_back(mk(-1,  0, -1,  7, -1, 0, 4,  9,   0, 0, 0, 0, 0, 0)); // 29 slot 7 was not valid
    tbl.push_back(mk( 0,  5, -1, -1, -1, 0, 0,  4,   0, 0, 0, 0, 0, 0)); // 30 rename x0 ignored
    tbl.push_back(mk( 1,  4, -1, -1, -1, 0, 1,  0,   4, 1, 0, 0, 0, 0)); // 31 rename x1->4
    tbl.push_back(mk(-1,  0, -1, -1,  7, 2, 1,  0,   0, 0, 0, 0, 0, 0)); // 32 mret flush beats paste
    tbl.push_back(mk(-1,  0, -1, -1,  7, 0, 1,  0,   0, 0, 0, 0, 1, 0)); // 33 paste of invalid slot
    tbl.push_back(mk(-1,  0, -1,  7, -1, 0, 1,  0,   0, 0, 0, 0, 0, 0)); // 34 mret cleared valid

    rst = 1'b1;
    drive(mk(-1, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      sb.push_back(tbl[i].e);
      @(posedge clk);
      #1;
      check_out(i);
    end
    chk("scoreboard_drained", 100, sb.size(), 0);

    // Rename is not bypassed to a same-cycle lookup of the same register
    @(negedge clk);
    drive(mk(10, 30, -1, -1, -1, 0, 10, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("no_bypass_busy", 200, int'(rs1_busy), 0);
    chk("no_bypass_tag",  200, int'(rs1_tag), 0);
    @(posedge clk);
    #1;
    chk("rename_seen_busy", 201, int'(rs1_busy), 1);
    chk("rename_seen_tag",  201, int'(rs1_tag), 30);

    // Synchronous reset mid-run clears live map and pulse outputs
    @(negedge clk);
    drive(mk(12, 5, -1, -1, 3, 0, 10, 12, 0, 0, 0, 0, 0, 0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_x10_busy",    202, int'(rs1_busy), 0);
    chk("rst_x12_tag",     202, int'(rs2_tag), 0);
    chk("rst_paste_done",  202, int'(paste_done), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(-1, 0, -1, -1, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
